// File: rtl/drr_port_arbiter_if.sv
// drr_port_arbiter_if
// Handshake bundle between the four ingress pointer FIFOs, the frame mover
// and the deficit-round-robin arbiter.
//   req_valid  per-port head frame present
//   req_len    per-port head frame length, port p at [p*LEN_W +: LEN_W]
//   bp         shared frame buffer full; blocks new grants only
//   xfer_done  one-cycle pulse from the mover when the granted frame is moved
//   grant      one-hot granted port, held for the whole transfer
//   grant_vld  grant and grant_len are valid
//   grant_len  length of the granted frame
// Modports: master = FIFO/mover side, slave = arbiter side.
interface drr_port_arbiter_if #(
  parameter int LEN_W = 11
);
  logic [3:0]         req_valid;
  logic [4*LEN_W-1:0] req_len;
  logic               bp;
  logic               xfer_done;
  logic [3:0]         grant;
  logic               grant_vld;
  logic [LEN_W-1:0]   grant_len;

  modport master (
    output req_valid, req_len, bp, xfer_done,
    input  grant, grant_vld, grant_len
  );

  modport slave (
    input  req_valid, req_len, bp, xfer_done,
    output grant, grant_vld, grant_len
  );
endinterface

// File: rtl/drr_port_arbiter.sv
// drr_port_arbiter
// Deficit-round-robin scheduler choosing which ingress port's head frame is
// moved next into the shared switch-core frame buffer. Each visit to a port
// adds its byte quantum to its deficit; frames are granted while the deficit
// covers the head-frame length. A grant is held until the mover pulses
// xfer_done, after which the same port may send again from its remainder.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   cfg_quantum  per-port quantum, port p at [p*Q_W +: Q_W]; 0 disables port
//   bus          handshake bundle (slave side)
//   busy         high whenever the scheduler is not idle
//   ptr_dbg      current round-robin pointer
module drr_port_arbiter #(
  parameter int LEN_W = 11,
  parameter int Q_W   = 12,
  parameter int DEF_W = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*Q_W-1:0]     cfg_quantum,
  drr_port_arbiter_if.slave    bus,
  output logic                 busy,
  output logic [1:0]           ptr_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VISIT = 2'd1,
    ST_CHECK = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [DEF_W-1:0] DEF_MAX = {DEF_W{1'b1}};

  state_t             state_r, state_s;
  logic [1:0]         ptr_r, ptr_s;
  logic [DEF_W-1:0]   deficit_r [4];
  logic [DEF_W-1:0]   deficit_s [4];
  logic [3:0]         grant_r, grant_s;
  logic               grant_vld_r, grant_vld_s;
  logic [LEN_W-1:0]   grant_len_r, grant_len_s;
  logic               busy_r;

  logic [Q_W-1:0]     cur_quantum_s;
  logic [LEN_W-1:0]   cur_len_s;
  logic               cur_req_s;
  logic [DEF_W-1:0]   cur_def_s;

  // Deficit plus quantum, clamped so a long-starved port can never wrap.
  function automatic logic [DEF_W-1:0] sat_add(input logic [DEF_W-1:0] def,
                                               input logic [Q_W-1:0]   q);
    logic [DEF_W:0] sum;
    sum = (DEF_W+1)'(def) + (DEF_W+1)'(q);
    if (sum[DEF_W]) begin
      return DEF_MAX;
    end else begin
      return sum[DEF_W-1:0];
    end
  endfunction

  // Select the quantum, head frame and deficit of the port under the pointer.
  always_comb begin
    cur_quantum_s = cfg_quantum[int'(ptr_r)*Q_W +: Q_W];
    cur_len_s     = bus.req_len[int'(ptr_r)*LEN_W +: LEN_W];
    cur_req_s     = bus.req_valid[ptr_r];
    cur_def_s     = deficit_r[ptr_r];
  end

  // Next-state and next-output logic of the scheduler.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    grant_s     = grant_r;
    grant_vld_s = grant_vld_r;
    grant_len_s = grant_len_r;
    for (int i = 0; i < 4; i++) begin
      deficit_s[i] = deficit_r[i];
    end

    case (state_r)
      ST_IDLE: begin
        if ((bus.req_valid != 4'd0) && !bus.bp) begin
          state_s = ST_VISIT;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_VISIT: begin
        // An empty or disabled port forfeits any saved credit.
        if (!cur_req_s || (cur_quantum_s == {Q_W{1'b0}})) begin
          deficit_s[ptr_r] = {DEF_W{1'b0}};
          ptr_s            = ptr_r + 2'd1;
          if (bus.req_valid == 4'd0) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_VISIT;
          end
        end else begin
          deficit_s[ptr_r] = sat_add(cur_def_s, cur_quantum_s);
          state_s          = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (bus.bp) begin
          state_s = ST_CHECK;
        end else if (cur_req_s && (cur_def_s >= DEF_W'(cur_len_s))) begin
          grant_s          = 4'b0001 << ptr_r;
          grant_vld_s      = 1'b1;
          grant_len_s      = cur_len_s;
          deficit_s[ptr_r] = cur_def_s - DEF_W'(cur_len_s);
          state_s          = ST_WAIT;
        end else if (!cur_req_s) begin
          deficit_s[ptr_r] = {DEF_W{1'b0}};
          ptr_s            = ptr_r + 2'd1;
          state_s          = ST_VISIT;
        end else begin
          // Credit kept for the next round; the head frame is too long for now.
          ptr_s   = ptr_r + 2'd1;
          state_s = ST_VISIT;
        end
      end

      ST_WAIT: begin
        // Return to CHECK on the same port so it can use its remaining credit.
        if (bus.xfer_done) begin
          grant_s     = 4'd0;
          grant_vld_s = 1'b0;
          state_s     = ST_CHECK;
        end else begin
          state_s = ST_WAIT;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, pointer, deficit and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 2'd0;
      grant_r     <= 4'd0;
      grant_vld_r <= 1'b0;
      grant_len_r <= {LEN_W{1'b0}};
      busy_r      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        deficit_r[i] <= {DEF_W{1'b0}};
      end
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      grant_r     <= grant_s;
      grant_vld_r <= grant_vld_s;
      grant_len_r <= grant_len_s;
      busy_r      <= (state_s != ST_IDLE);
      for (int i = 0; i < 4; i++) begin
        deficit_r[i] <= deficit_s[i];
      end
    end
  end

  assign bus.grant     = grant_r;
  assign bus.grant_vld = grant_vld_r;
  assign bus.grant_len = grant_len_r;
  assign busy          = busy_r;
  assign ptr_dbg       = ptr_r;

endmodule

// File: doc/drr_port_arbiter.md
Name: drr_port_arbiter

Overview:
- Deficit-round-robin scheduler for the four ingress ports that feed the shared switch-core frame buffer.
- Decides which port's head frame is moved next, weighting ports by a per-port byte quantum.
- Holds a grant until the mover reports the transfer complete.
- Replaces plain round-robin with byte-fair sharing, under backpressure from the shared buffer.

Parameters:
- LEN_W, 11, width of a frame length in bytes (max frame 2047).
- Q_W, 12, width of each per-port quantum.
- DEF_W, 14, width of each per-port deficit counter; saturates at 2^DEF_W-1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_quantum  in  4*Q_W  per-port quantum, port p at [p*Q_W +: Q_W]; 0 disables the port.
- req_valid  in  4  port p's ingress pointer FIFO is non-empty.
- req_len  in  4*LEN_W  head-frame length of port p at [p*LEN_W +: LEN_W]; valid while req_valid[p].
- bp  in  1  shared buffer cannot accept a frame; blocks new grants only.
- grant  out  4  one-hot port granted; held for the whole transfer.
- grant_vld  out  1  grant and grant_len are valid.
- grant_len  out  LEN_W  length of the granted frame.
- xfer_done  in  1  one-cycle pulse from the mover when the granted frame is fully moved.
- busy  out  1  high in any state other than IDLE.
- ptr_dbg  out  2  current round-robin pointer.

Behaviour:
- Reset: grant=0, grant_vld=0, grant_len=0, busy=0, ptr=0, all deficits=0, state=IDLE. Reset mid-WAIT drops the grant on the same edge; the mover discards partial work.
- State IDLE:
  - If req_valid!=0 and !bp, go to VISIT.
  - Otherwise stay in IDLE.
- State VISIT (1 cycle per port visited):
  - If !req_valid[ptr] or quantum[ptr]==0: deficit[ptr]<=0 and ptr<=ptr+1 mod 4. Go to IDLE if req_valid==0, otherwise stay in VISIT.
  - Otherwise: deficit[ptr] <= min(deficit+quantum, 2^DEF_W-1) and go to CHECK.
- State CHECK:
  - If bp, hold with no changes.
  - Else if req_valid[ptr] and deficit[ptr]>=req_len[ptr]:
    - grant<=1<<ptr, grant_vld<=1, grant_len<=req_len[ptr].
    - deficit[ptr]<=deficit-req_len (unsigned, never negative).
    - Go to WAIT.
  - Else if !req_valid[ptr]: deficit<=0, ptr++, go to VISIT.
  - Else (deficit too small): keep deficit, ptr++, go to VISIT.
- State WAIT:
  - grant, grant_vld and grant_len are stable.
  - bp and req changes are ignored.
  - On xfer_done: grant<=0, grant_vld<=0, go to CHECK on the same ptr with no quantum added, so the port may send further frames within its remaining deficit.
- Latency: request on the port at ptr, sampled in IDLE at edge N, gives grant_vld=1 after edge N+2. Each skipped port adds 1 cycle.
- Grant-to-regrant on the same port: xfer_done at edge M gives the next grant_vld after edge M+1.
- xfer_done outside WAIT is ignored.
- req_len==0 is granted with the deficit unchanged (a mover error, not an arbiter error).
- cfg_quantum is sampled only in VISIT; changes take effect at the next visit.
- Any port with quantum>0 and a pending frame is served within ceil(len/quantum) rounds. Saturation keeps deficit ≥ 2047 reachable.

Test Plan:
- Single port: quanta=1536, port 0 has four 600-byte frames.
  - Grants 600, 600 (deficit 936→336).
  - Then moves on; the next visit gives deficit 1872 → two more grants.
  - Empty queue clears deficit to 0.
- Fairness: all ports saturated with 64-byte frames, quantum0=1024, quantum1..3=256, 4000 grants.
  - Port 0 gets 4×±1% of each other port's grant count.
- Small quantum: quantum2=100, single 1500-byte frame on port 2 only.
  - Granted on the 15th visit (deficit 1500), residual 0.
  - grant_len=1500.
- Backpressure: bp high in CHECK with a grantable frame → no grant while high. Grant appears the cycle after bp falls. bp raised during WAIT does not drop the grant.
- Disable: quantum1=0 with port 1 requesting → never granted, deficit1 stays 0; other ports unaffected.
- Reset mid-WAIT: rst pulsed while grant_vld=1 → all outputs 0 after that edge, ptr=0. A stray xfer_done afterwards is ignored.
